// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width, byte type and default receive FIFO depth.
package uart_pkg;

    localparam int UART_DATA_W   = 8;
    localparam int RX_FIFO_DEPTH = 16;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Purpose: DEPTH x DATA_W register array, one write port and one asynchronous read port.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none, the caller gates we.
module rx_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage only; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: receive byte FIFO behind the UART receiver, rising-edge write capture, valid/ready pop;
//   optional registered almost_full via UART_RX_FIFO_AF_EN.
// Latency: byte written at edge N appears on rd_data/rd_valid after edge N (first-word fall-through).
// Backpressure: none toward the receiver; a write into a full FIFO with no pop is dropped and sets overflow.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
`ifdef UART_RX_FIFO_AF_EN
    ,
    parameter int AF_THRESH = DEPTH - 2
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       data_valid,
    input  logic [DATA_W-1:0]          p_data,
    input  logic                       rd_ready,
    input  logic                       flush,
    input  logic                       ovf_clr,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
`ifdef UART_RX_FIFO_AF_EN
    ,
    output logic                       almost_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic          dv_q;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_evt;
    logic          pop;
    logic          full;
    logic          wr_acc;
    logic          wr_rej;
    logic [CW-1:0] level_nxt;
    logic [DATA_W-1:0] mem_rdata;

    assign wr_evt   = data_valid & ~dv_q;
    assign rd_valid = (level != '0);
    assign pop      = rd_valid & rd_ready;
    assign full     = (level == CW'(DEPTH));
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign wr_acc   = wr_evt & (~full | pop);
    assign wr_rej   = wr_evt & full & ~pop;

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            case ({wr_acc, pop})
                2'b10:   level_nxt = level + CW'(1);
                2'b01:   level_nxt = level - CW'(1);
                default: level_nxt = level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_q     <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            dv_q  <= data_valid;
            level <= level_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
                if (pop)    rd_ptr <= rd_ptr + AW'(1);
            end
            // Set beats clear so a drop coinciding with ovf_clr is never lost.
            if (wr_rej) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_AF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            almost_full <= 1'b0;
        end else begin
            almost_full <= (level_nxt >= CW'(AF_THRESH));
        end
    end
`endif

    rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc & ~flush),
        .waddr (wr_ptr),
        .wdata (p_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    assign rd_data = rd_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: vector table, directed corner sequences and a queue-model random run.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       data_valid;
    logic [7:0] p_data;
    logic       rd_ready;
    logic       flush;
    logic       ovf_clr;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [4:0] level;
    logic       overflow;
`ifdef UART_RX_FIFO_AF_EN
    logic       almost_full;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    uart_rx_fifo #(.DEPTH(16), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_valid (data_valid),
        .p_data     (p_data),
        .rd_ready   (rd_ready),
        .flush      (flush),
        .ovf_clr    (ovf_clr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .level      (level),
        .overflow   (overflow)
`ifdef UART_RX_FIFO_AF_EN
        ,
        .almost_full(almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       dv;
        logic [7:0] pd;
        logic       rr;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic [4:0] exp_level;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_valid = 1'b1;
        p_data     = b;
        tick();
        data_valid = 1'b0;
        tick();
    endtask

    // Reference model state: queue of stored bytes, registered data_valid, sticky flag.
    logic [7:0] mq[$];
    logic       m_dvq;
    logic       m_ovf;

    task automatic model_step(input logic dv, input logic [7:0] pd, input logic rr,
                              input logic fl, input logic oc);
        int  sz;
        logic do_pop, do_wr;
        sz     = mq.size();
        do_pop = (sz != 0) && rr;
        do_wr  = dv && !m_dvq;
        if (do_wr && sz == 16 && !do_pop) m_ovf = 1'b1;
        else if (oc) m_ovf = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_wr && (sz < 16 || do_pop)) mq.push_back(pd);
        end
        m_dvq = dv;
    endtask

    initial begin
        logic [7:0] exp_d;
        int rr_pct;
        logic r_dv, r_rr, r_fl, r_oc;
        logic [7:0] r_pd;

        rst = 1'b0; data_valid = 1'b0; p_data = 8'h00;
        rd_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        #3;
        check("reset_valid", rd_valid, 0);
        check("reset_level", level, 0);
        check("reset_ovf", overflow, 0);
        check("reset_data", rd_data, 0);
`ifdef UART_RX_FIFO_AF_EN
        check("reset_af", almost_full, 0);
`endif
        #8 rst = 1'b1;

        // Pulsed writes with pops, held data_valid, and write+pop on an empty FIFO.
        vecs[0]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 5'd1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 5'd1, 1'b0};
        vecs[2]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 8'h55, 5'd2, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 5'd1, 1'b0};
        vecs[4]  = '{1'b1, 8'h0F, 1'b0, 1'b1, 8'hA3, 5'd2, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h0F, 5'd1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[7]  = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0};
        vecs[8]  = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0};
        vecs[9]  = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0};
        vecs[10] = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0};
        vecs[11] = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h7E, 5'd1, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
        vecs[14] = '{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 5'd1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

        tick();
        for (int i = 0; i < 16; i++) begin
            data_valid = vecs[i].dv;
            p_data     = vecs[i].pd;
            rd_ready   = vecs[i].rr;
            tick();
            check($sformatf("vec%0d_valid", i), rd_valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
            check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
            check($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
        end
        data_valid = 1'b0; rd_ready = 1'b0;
        tick();

        // 17 writes into a 16-deep FIFO: last byte is dropped.
        for (int i = 0; i <= 16; i++) begin
            write_byte(8'(i));
`ifdef UART_RX_FIFO_AF_EN
            check($sformatf("fill_af%0d", i), almost_full, (i + 1 >= 14) ? 1 : 0);
`endif
        end
        check("full_level", level, 16);
        check("full_ovf", overflow, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), rd_data, i);
            tick();
`ifdef UART_RX_FIFO_AF_EN
            check($sformatf("drain_af%0d", i), almost_full, (15 - i >= 14) ? 1 : 0);
`endif
        end
        rd_ready = 1'b0;
        check("drained_level", level, 0);
        check("drained_valid", rd_valid, 0);
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 0);

        // Full FIFO, write coinciding with a pop is accepted.
        for (int i = 0; i < 16; i++) write_byte(8'hA0 + 8'(i));
        data_valid = 1'b1; p_data = 8'h99; rd_ready = 1'b1;
        tick();
        data_valid = 1'b0;
        check("wpop_level", level, 16);
        check("wpop_ovf", overflow, 0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("wpop_drain%0d", i), rd_data, 8'hA0 + 8'(i));
            tick();
        end
        check("wpop_last", rd_data, 8'h99);
        tick();
        rd_ready = 1'b0;
        check("wpop_empty", level, 0);

        // Set beats clear, then flush with write and pop in the same cycle.
        for (int i = 0; i < 16; i++) write_byte(8'(i));
        data_valid = 1'b1; p_data = 8'hEE; ovf_clr = 1'b1;
        tick();
        data_valid = 1'b0; ovf_clr = 1'b0;
        check("setwins_ovf", overflow, 1);
        tick();
        data_valid = 1'b1; p_data = 8'h44; rd_ready = 1'b1; flush = 1'b1;
        tick();
        data_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
        check("flush_level", level, 0);
        check("flush_valid", rd_valid, 0);
        check("flush_ovf", overflow, 1);
        tick();
        write_byte(8'h12);
        check("postflush_data", rd_data, 8'h12);
        check("postflush_level", level, 1);

        // Async reset with five stored bytes and overflow set.
        for (int i = 0; i < 4; i++) write_byte(8'h20 + 8'(i));
        check("prerst_level", level, 5);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", rd_valid, 0);
        check("arst_level", level, 0);
        check("arst_ovf", overflow, 0);
        #2 rst = 1'b1;
        tick();

        // Randomized traffic against the queue model.
        mq.delete(); m_dvq = 1'b0; m_ovf = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rr_pct = ((c / 100) % 2 == 0) ? 15 : 85;
            r_dv = 1'($urandom_range(0, 1));
            r_pd = 8'($urandom);
            r_rr = ($urandom_range(0, 99) < rr_pct);
            r_fl = !r_dv && ($urandom_range(0, 99) < 2);
            r_oc = ($urandom_range(0, 99) < 4);
            data_valid = r_dv; p_data = r_pd; rd_ready = r_rr; flush = r_fl; ovf_clr = r_oc;
            model_step(r_dv, r_pd, r_rr, r_fl, r_oc);
            tick();
            exp_d = (mq.size() != 0) ? mq[0] : 8'h00;
            check("rnd_level", level, mq.size());
            check("rnd_valid", rd_valid, (mq.size() != 0) ? 1 : 0);
            check("rnd_data", rd_data, exp_d);
            check("rnd_ovf", overflow, m_ovf);
`ifdef UART_RX_FIFO_AF_EN
            check("rnd_af", almost_full, (mq.size() >= 14) ? 1 : 0);
`endif
        end
        data_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0; ovf_clr = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
